// File: rtl/rr_ring_arbiter_pkg.sv
// Shared types and helpers for the round-robin ring arbiter.
package rr_arb_pkg;

   // Widest requester vector the helpers handle (N <= 16).
   localparam int unsigned MAX_N     = 16;
   localparam int unsigned MAX_IDX_W = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   // Rotate a one-hot vector of n live bits left by one; bit n-1 wraps to bit 0.
   function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int unsigned n);
      logic [MAX_N-1:0] live_mask;
      live_mask = MAX_N'((33'd1 << n) - 33'd1);
      return ((v << 1) | (v >> (n - 1))) & live_mask;
   endfunction

   // Binary index of the set bit of a one-hot vector (0 for an all-zero vector).
   function automatic logic [MAX_IDX_W-1:0] onehot2idx(input logic [MAX_N-1:0] v);
      logic [MAX_IDX_W-1:0] idx;
      idx = '0;
      for (int unsigned i = 0; i < MAX_N; i++) begin
         if (|(v & (MAX_N'(1) << i))) idx = idx | MAX_IDX_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/rr_ring_arbiter_pick.sv
// Combinational circular priority picker: lowest set Req bit at or above the
// one-hot pointer, wrapping past bit N-1 back to bit 0.
module rr_pick
   import rr_arb_pkg::*;
#(
   parameter int unsigned N = 4
) (
   input  logic [N-1:0] Req,
   input  logic [N-1:0] Priority_ptr,
   output logic [N-1:0] Winner,
   output logic         Valid
);

   logic [2*N-1:0] req_dbl;
   logic [2*N-1:0] ptr_mask;
   logic [2*N-1:0] masked;
   logic [2*N-1:0] lowest;

   // Lower copy keeps only bits at/above the pointer; the upper copy supplies the wrap.
   always_comb begin
      req_dbl  = {Req, Req};
      ptr_mask = {{N{1'b1}}, ~(Priority_ptr - N'(1))};
      masked   = req_dbl & ptr_mask;
      lowest   = masked & (~masked + (2*N)'(1));
      Winner   = lowest[N-1:0] | lowest[2*N-1:N];
      Valid    = |Req;
   end

endmodule

// File: rtl/rr_ring_arbiter.sv
// Round-robin arbiter with a one-hot priority ring; grants are held until the
// owner releases. Optional forced release after MAX_HOLD cycles when the
// macro HOLD_TIMEOUT_EN is defined.
module rr_ring_arbiter
   import rr_arb_pkg::*;
#(
   parameter int unsigned N        = 4,
   parameter int unsigned IDX_W    = 2,
   parameter int unsigned MAX_HOLD = 15
) (
   input  logic             Clock,
   input  logic             Reset_n,
   input  logic [N-1:0]     Req,
   input  logic             Done,
   output logic [N-1:0]     Grant,
   output logic [IDX_W-1:0] Grant_idx,
   output logic             Busy,
   output logic [N-1:0]     Priority_ptr,
   output logic             Timeout
);

   state_t           state_q, state_d;
   logic [N-1:0]     grant_q, grant_d;
   logic [N-1:0]     ptr_q, ptr_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic [N-1:0]     winner;
   logic             win_valid;
   logic             owner_req;
   logic             force_rel;

   rr_pick #(.N(N)) u_pick (
      .Req          (Req),
      .Priority_ptr (ptr_q),
      .Winner       (winner),
      .Valid        (win_valid)
   );

   assign owner_req = |(Req & grant_q);

   // State, grant and priority ring registers.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= IDLE;
         grant_q <= '0;
         idx_q   <= '0;
         ptr_q   <= N'(1);
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
         ptr_q   <= ptr_d;
      end
   end

   // Next state: pick a winner in IDLE, release on Done, withdrawal or hold limit.
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      idx_d   = idx_q;
      ptr_d   = ptr_q;
      case (state_q)
         IDLE: begin
            if (win_valid) begin
               state_d = GRANT;
               grant_d = winner;
               idx_d   = IDX_W'(onehot2idx(MAX_N'(winner)));
            end
         end
         GRANT: begin
            if (Done || !owner_req || force_rel) begin
               state_d = IDLE;
               grant_d = '0;
               idx_d   = '0;
               ptr_d   = N'(rotl1(MAX_N'(grant_q), N));
            end
         end
         default: state_d = IDLE;
      endcase
   end

`ifdef HOLD_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(MAX_HOLD + 1);

   logic [CNT_W-1:0] hold_q;
   logic             timeout_q;

   assign force_rel = (state_q == GRANT) && (hold_q == CNT_W'(MAX_HOLD));

   // Hold counter sits at 0 outside GRANT so it restarts on every new grant.
   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         hold_q    <= '0;
         timeout_q <= 1'b0;
      end else begin
         hold_q    <= (state_q == GRANT && state_d == GRANT) ? hold_q + CNT_W'(1) : '0;
         timeout_q <= force_rel && !Done && owner_req;
      end
   end

   assign Timeout = timeout_q;
`else
   // MAX_HOLD only matters when the hold timeout is built in.
   logic unused_max_hold;
   assign unused_max_hold = (MAX_HOLD != 0);
   assign force_rel       = 1'b0;
   assign Timeout         = 1'b0;
`endif

   assign Grant        = grant_q;
   assign Grant_idx    = idx_q;
   assign Busy         = (state_q == GRANT);
   assign Priority_ptr = ptr_q;

endmodule
